// File: rtl/snax_simbacore_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// snax_simbacore_ctrl_pkg: FSM states, CSR word and status bit indices.  Rev 1.0
// ----------------------------------------------------------------------------
package snax_simbacore_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CFG  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned CsrMode   = 0;
  localparam int unsigned CsrSeqLen = 1;
  localparam int unsigned CsrDModel = 2;
  localparam int unsigned CsrDtRank = 3;
  localparam int unsigned CsrDInner = 4;
  localparam int unsigned CsrBeats  = 5;

  localparam int unsigned StBusy = 0;
  localparam int unsigned StDone = 1;
  localparam int unsigned StErr  = 2;

  localparam int unsigned NumModes = 4;

endpackage
`default_nettype wire

// File: rtl/snax_simbacore_beat_ctr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// snax_simbacore_beat_ctr: saturating popcount accumulator with target compare.  Rev 1.0
// ----------------------------------------------------------------------------
module snax_simbacore_beat_ctr
  import snax_simbacore_ctrl_pkg::*;
#(
  parameter int unsigned NumOut   = 3,
  parameter int unsigned CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                en_i,
  input  logic [NumOut-1:0]   fire_i,
  input  logic [CntWidth-1:0] target_i,
  output logic                reach_o
);

  logic [CntWidth-1:0] count_q, count_d, pop_w;
  logic [CntWidth:0]   sum_w;

  always_comb begin
    pop_w = '0;
    for (int i = 0; i < NumOut; i++) begin
      pop_w = pop_w + CntWidth'(fire_i[i]);
    end
  end

  // One extra bit so the compare stays correct near the top of the range.
  assign sum_w   = {1'b0, count_q} + {1'b0, pop_w};
  assign reach_o = en_i && (sum_w >= {1'b0, target_i});

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = reach_o ? target_i : sum_w[CntWidth-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/snax_simbacore_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// snax_simbacore_ctrl: CSR job latch, SimbaCore config handshake, beat/cycle status.
// Optional cycle counter: SNAX_SIMBACORE_CTRL_PERF_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module snax_simbacore_ctrl #(
  parameter int unsigned RegRWCount   = 6,
  parameter int unsigned RegROCount   = 2,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned NumOut       = 3,
  parameter int unsigned NumModes     = snax_simbacore_ctrl_pkg::NumModes
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [RegRWCount*RegDataWidth-1:0] csr_reg_set_i,
  input  logic                               csr_reg_set_valid_i,
  output logic                               csr_reg_set_ready_o,
  output logic [RegROCount*RegDataWidth-1:0] csr_reg_ro_set_o,
  output logic                               core_cfg_valid_o,
  input  logic                               core_cfg_ready_i,
  output logic [RegDataWidth-1:0]            core_cfg_mode_o,
  output logic [RegDataWidth-1:0]            core_cfg_seqlen_o,
  output logic [RegDataWidth-1:0]            core_cfg_dmodel_o,
  output logic [RegDataWidth-1:0]            core_cfg_dtrank_o,
  output logic [RegDataWidth-1:0]            core_cfg_dinner_o,
  input  logic [NumOut-1:0]                  out_fire_i,
  output logic                               done_o
);
  import snax_simbacore_ctrl_pkg::*;

  localparam int unsigned DW = RegDataWidth;

  state_e        state_q, state_d;
  logic [DW-1:0] job_w [RegRWCount];
  logic [DW-1:0] beats_q, cycles_w;
  logic          busy_q, done_q, err_q;
  logic          accept_w, bad_w, good_w, active_w, reach_w;

  for (genvar i = 0; i < RegRWCount; i++) begin : g_job
    assign job_w[i] = csr_reg_set_i[i*DW +: DW];
  end

  assign csr_reg_set_ready_o = (state_q == IDLE);
  assign accept_w = csr_reg_set_valid_i && csr_reg_set_ready_o;
  assign bad_w    = (job_w[CsrMode] >= DW'(NumModes)) || (job_w[CsrBeats] == '0);
  assign good_w   = accept_w && !bad_w;
  assign active_w = (state_q == CFG) || (state_q == RUN);
  assign core_cfg_valid_o = (state_q == CFG);
  assign done_o   = (state_q == DONE);

  snax_simbacore_beat_ctr #(
    .NumOut   (NumOut),
    .CntWidth (DW)
  ) i_beat_ctr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (good_w),
    .en_i     (active_w),
    .fire_i   (out_fire_i),
    .target_i (beats_q),
    .reach_o  (reach_w)
  );

  // Reaching the target wins over a same-cycle config handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (good_w) state_d = CFG;
      CFG: begin
        if (reach_w) state_d = DONE;
        else if (core_cfg_ready_i) state_d = RUN;
      end
      RUN:     if (reach_w) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= IDLE;
      core_cfg_mode_o   <= '0;
      core_cfg_seqlen_o <= '0;
      core_cfg_dmodel_o <= '0;
      core_cfg_dtrank_o <= '0;
      core_cfg_dinner_o <= '0;
      beats_q           <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      err_q             <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_w && bad_w) begin
        err_q  <= 1'b1;
        done_q <= 1'b0;
      end else if (good_w) begin
        core_cfg_mode_o   <= job_w[CsrMode];
        core_cfg_seqlen_o <= job_w[CsrSeqLen];
        core_cfg_dmodel_o <= job_w[CsrDModel];
        core_cfg_dtrank_o <= job_w[CsrDtRank];
        core_cfg_dinner_o <= job_w[CsrDInner];
        beats_q           <= job_w[CsrBeats];
        err_q             <= 1'b0;
        done_q            <= 1'b0;
        busy_q            <= 1'b1;
      end
      if (active_w && reach_w) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

`ifdef SNAX_SIMBACORE_CTRL_PERF_EN
  logic [31:0] cycles_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || good_w) begin
      cycles_q <= '0;
    end else if (active_w && (cycles_q != '1)) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  assign cycles_w = DW'(cycles_q);
`else
  assign cycles_w = '0;
`endif

  // Status word occupies the lowest word, so bit indices map directly.
  always_comb begin
    csr_reg_ro_set_o         = '0;
    csr_reg_ro_set_o[StBusy] = busy_q;
    csr_reg_ro_set_o[StDone] = done_q;
    csr_reg_ro_set_o[StErr]  = err_q;
    csr_reg_ro_set_o[DW +: DW] = cycles_w;
  end

endmodule
`default_nettype wire

// File: tb/tb_snax_simbacore_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_snax_simbacore_ctrl: directed jobs with a queued-expectation monitor.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_snax_simbacore_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [191:0] csr_set;
  logic         csr_valid, csr_ready;
  logic [63:0]  ro;
  logic         cfg_valid, cfg_ready;
  logic [31:0]  mode_o, seqlen_o, dmodel_o, dtrank_o, dinner_o;
  logic [2:0]   fire;
  logic         done;
  logic [159:0] fields_w;

  int total = 0;
  int bad   = 0;
  int ndone = 0;
  int cyc   = 0;

  typedef struct {logic [159:0] f; int c;} cfg_t;
  typedef struct {int c; logic [31:0] st; logic [31:0] cy;} dn_t;
  cfg_t cfg_q[$];
  dn_t  dn_q[$];

  snax_simbacore_ctrl dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .csr_reg_set_i       (csr_set),
    .csr_reg_set_valid_i (csr_valid),
    .csr_reg_set_ready_o (csr_ready),
    .csr_reg_ro_set_o    (ro),
    .core_cfg_valid_o    (cfg_valid),
    .core_cfg_ready_i    (cfg_ready),
    .core_cfg_mode_o     (mode_o),
    .core_cfg_seqlen_o   (seqlen_o),
    .core_cfg_dmodel_o   (dmodel_o),
    .core_cfg_dtrank_o   (dtrank_o),
    .core_cfg_dinner_o   (dinner_o),
    .out_fire_i          (fire),
    .done_o              (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign fields_w = {mode_o, seqlen_o, dmodel_o, dtrank_o, dinner_o};

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cfg_valid && cfg_ready) begin
        cfg_t e;
        if (cfg_q.size() == 0) chk("cfg_unexpected", 160'(1), 160'(0));
        else begin
          e = cfg_q.pop_front();
          chk("cfg_fields", fields_w, e.f);
          chk("cfg_cycle", 160'(cyc), 160'(e.c));
        end
      end
      if (done) begin
        dn_t d;
        ndone++;
        if (dn_q.size() == 0) chk("done_unexpected", 160'(1), 160'(0));
        else begin
          d = dn_q.pop_front();
          chk("done_cycle", 160'(cyc), 160'(d.c));
          chk("done_status", 160'(ro[31:0]), 160'(d.st));
          chk("done_cycles", 160'(ro[63:32]), 160'(d.cy));
        end
      end
    end
  end

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef SNAX_SIMBACORE_CTRL_PERF_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  // fpat holds the out_fire_i value for CFG/RUN cycle k in bits [3k+2:3k].
  task automatic do_job(input logic [31:0] m, sl, dm, dr, di, bt, input int rdy_lo,
                        input logic [47:0] fpat, input int doff, input logic [31:0] ecyc);
    int a;
    int n0;
    csr_set   = {bt, di, dr, dm, sl, m};
    csr_valid = 1'b1;
    cfg_ready = 1'b0;
    fire      = 3'b000;
    chk("set_ready_idle", 160'(csr_ready), 160'(1));
    tick();
    a = cyc;
    csr_valid = 1'b0;
    cfg_q.push_back('{{m, sl, dm, dr, di}, a + rdy_lo});
    dn_q.push_back('{a + doff, 32'h2, perf(ecyc)});
    n0 = ndone;
    chk("busy_status", 160'(ro[31:0]), 160'(1));
    for (int k = 0; k < 24 && ndone == n0; k++) begin
      cfg_ready = (k >= rdy_lo);
      fire      = (k < 16) ? fpat[k*3 +: 3] : 3'b000;
      if (k < rdy_lo) begin
        chk("cfg_valid_wait", 160'(cfg_valid), 160'(1));
        chk("set_ready_busy", 160'(csr_ready), 160'(0));
        chk("cfg_stable", fields_w, {m, sl, dm, dr, di});
      end
      tick();
    end
    fire      = 3'b000;
    cfg_ready = 1'b0;
    if (ndone == n0) begin
      chk("done_timeout", 160'(0), 160'(1));
      dn_q.delete();
      cfg_q.delete();
    end
    tick();
    tick();
    chk("status_held", 160'(ro[31:0]), 160'(2));
    chk("cycles_held", 160'(ro[63:32]), 160'(perf(ecyc)));
    chk("cfg_valid_idle", 160'(cfg_valid), 160'(0));
  endtask

  task automatic bad_job(input logic [31:0] m, input logic [31:0] bt);
    csr_set   = {bt, 32'd1, 32'd1, 32'd1, 32'd1, m};
    csr_valid = 1'b1;
    tick();
    csr_valid = 1'b0;
    chk("err_status", 160'(ro[31:0]), 160'(4));
    chk("err_no_cfg", 160'(cfg_valid), 160'(0));
    chk("err_ready", 160'(csr_ready), 160'(1));
    tick();
    chk("err_no_cfg2", 160'(cfg_valid), 160'(0));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, 160'(csr_ready), 160'(1));
    chk({tag, "_cfg_valid"}, 160'(cfg_valid), 160'(0));
    chk({tag, "_done"}, 160'(done), 160'(0));
    chk({tag, "_ro"}, 160'(ro), 160'(0));
    chk({tag, "_fields"}, fields_w, 160'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    rst = 1'b1; csr_set = '0; csr_valid = 1'b0; cfg_ready = 1'b0; fire = 3'b000;
    tick(); tick(); tick();
    rst = 1'b0;
    chk_reset_state("rst");

    // T1: one beat per cycle, config accepted immediately
    do_job(32'd1, 32'd8, 32'd16, 32'd2, 32'd32, 32'd4, 0,
           48'({3'b001, 3'b100, 3'b010, 3'b001}), 4, 32'd4);
    // T2: config stalled 5 cycles; handshake and final beat coincide
    do_job(32'd2, 32'd12, 32'd64, 32'd4, 32'd128, 32'd2, 5,
           48'({3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000}), 6, 32'd6);
    // T3: 3+3 beats against a target of 5
    do_job(32'd3, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 0,
           48'({3'b111, 3'b111}), 2, 32'd2);
    // T4: illegal mode, then zero beats
    bad_job(32'd7, 32'd3);
    bad_job(32'd0, 32'd0);
    // T6 (also clears err): beats at cycles 3 and 6 after CFG entry
    do_job(32'd0, 32'd5, 32'd6, 32'd7, 32'd8, 32'd2, 0,
           48'({3'b100, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000}), 7, 32'd7);

    // T5: reset while running
    csr_set   = {32'd10, 32'd9, 32'd9, 32'd9, 32'd9, 32'd1};
    csr_valid = 1'b1;
    cfg_ready = 1'b1;
    tick();
    a = cyc;
    csr_valid = 1'b0;
    cfg_q.push_back('{{32'd1, 32'd9, 32'd9, 32'd9, 32'd9}, a});
    fire = 3'b001; tick();
    fire = 3'b011; tick();
    rst = 1'b1; fire = 3'b111; tick();
    rst = 1'b0; fire = 3'b000; cfg_ready = 1'b0;
    chk_reset_state("midrst");
    do_job(32'd2, 32'd4, 32'd8, 32'd1, 32'd16, 32'd3, 1,
           48'({3'b001, 3'b001, 3'b001}), 3, 32'd3);

    tick();
    chk("cfg_q_empty", 160'(cfg_q.size()), 160'(0));
    chk("dn_q_empty", 160'(dn_q.size()), 160'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
